alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-side consumer of the 4-bit alu_control code produced by the ALU decoder.
//  Accepts one operation per valid/ready handshake, computes it, and holds the
//  registered result until downstream accepts it.
//  Sits between the decode/register-read stage and writeback/branch resolution
//  of the multi-cycle core variant.
//  Shifts, when enabled, are iterative: one bit per cycle.
// PARAMETERS
//  XLEN    32             operand/result width in bits
//  SHAMT_W $clog2(XLEN)   shift-amount width (derived localparam, not overridable)
// PORTS
//  clk          in   1     rising-edge clock; the block's only clock
//  rst_n        in   1     asynchronous, active-low reset
//  in_valid     in   1     operation presented on alu_control/src_a/src_b
//  in_ready     out  1     unit can accept an operation this cycle
//  alu_control  in   4     0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLT,
//                          0011 SLL*, 0100 SRL* (*macro only); all others illegal
//  src_a        in   XLEN  operand A
//  src_b        in   XLEN  operand B; shift amount = src_b[SHAMT_W-1:0]
//  out_valid    out  1     result/zero/illegal are valid
//  out_ready    in   1     downstream accepts the result
//  result       out  XLEN  registered result
//  zero         out  1     result == 0 (used for BEQ via SUB)
//  illegal      out  1     code was not a supported operation
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0;
//    result=0; zero=1; illegal=0; shift counter=0.
//    Reset mid-operation abandons the operation; no output is produced for it.
//  - Accept: in_valid && in_ready.
//    Capture alu_control and operands only on accept; inputs are ignored otherwise.
//  - FSM states and transitions:
//    - IDLE: accept -> DONE (single-cycle op), or -> SHIFT (shift op with shamt != 0).
//      A shift with shamt == 0 goes -> DONE with result = src_a.
//    - SHIFT: in_ready=0. Each cycle, shift the working register by 1 (SLL: zero-fill
//      from LSB; SRL: logical, zero-fill from MSB) and decrement the counter.
//      Counter reaching 0 -> DONE.
//    - DONE: out_valid=1. Every output is stable while !out_ready.
//      out_ready && !accept -> IDLE.
//      out_ready && accept  -> DONE or SHIFT per the new op (back-to-back).
//  - in_ready = (state==IDLE) || (state==DONE && out_ready).
//  - Latency from accept to out_valid:
//    - single-cycle ops: 1 cycle;
//    - shift: 1 + shamt cycles.
//    Throughput is 1 op/cycle when out_ready is held high.
//  - Arithmetic: ADD/SUB are mod 2^XLEN; carry and overflow are discarded.
//    SLT is a signed compare; result = {XLEN-1 zeros, (a<b)}.
//  - Illegal code: result=0, zero=1, illegal=1. Latency 1; the handshake is unchanged.
//    illegal=0 for every legal op.
//  - zero is computed from the value loaded into result, in the same register stage.
//  - out_valid never drops without out_ready; outputs never change while waiting.
// CONFIGURATION
//  ALU_SHIFT_EN defined:
//    - 0011=SLL and 0100=SRL are legal and run through the SHIFT state;
//    - shift counter and working register are present.
//  ALU_SHIFT_EN undefined:
//    - 0011/0100 are treated as illegal;
//    - SHIFT state, counter and working register are not built;
//    - FSM is IDLE/DONE only; every op has latency 1.
// TESTING
//  1 ADD a=5,b=7, out_ready=1 -> next cycle out_valid=1, result=12, zero=0, illegal=0.
//  2 SUB a=b=0x1234 -> result=0, zero=1.
//    Then SLT a=0xFFFFFFFF, b=1 -> result=1 (signed).
//    Both issued back-to-back; one result per cycle.
//  3 Code 1111, a=3, b=4 -> result=0, zero=1, illegal=1, latency 1.
//  4 AND a=0xF0F0, b=0xFF00 with out_ready=0 for 4 cycles:
//    -> result=0xF000 held stable, in_ready=0, out_valid=1.
//    Release -> one transfer, then IDLE.
//  5 [ALU_SHIFT_EN] SLL a=1, b=4 -> out_valid after 5 cycles, result=16.
//    SRL a=0x80000000, b=31 -> result=1 after 32 cycles.
//    shamt=0 -> result=a at latency 1.
//  6 Assert rst_n=0 mid-SHIFT -> immediately out_valid=0, in_ready=1, result=0.
//    No stale result appears after release.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute unit for the 4-bit alu_control code: valid/ready in, registered result held until accepted.
// Optional iterative one-bit-per-cycle SLL/SRL is built only when ALU_SHIFT_EN is defined.
`timescale 1ns/1ps
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

`ifdef ALU_SHIFT_EN
  localparam int SHAMT_W = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, DONE, SHIFT} state_t;
`else
  typedef enum logic {IDLE, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;
  logic              accept;
  logic [XLEN-1:0]   op_res;
  logic              op_ill;
  logic signed [XLEN-1:0] a_s, b_s;

`ifdef ALU_SHIFT_EN
  logic [SHAMT_W-1:0] shamt;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]    work_q, work_d;
  logic               srl_q, srl_d;
  logic               op_shift;

  assign shamt = src_b[SHAMT_W-1:0];
`endif

  assign a_s = src_a;
  assign b_s = src_b;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  // Operation decode and single-cycle datapath; illegal codes leave op_res at zero
  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
`ifdef ALU_SHIFT_EN
    op_shift = 1'b0;
`endif
    case (alu_control)
      4'b0010: op_res = src_a + src_b;
      4'b0110: op_res = src_a - src_b;
      4'b0000: op_res = src_a & src_b;
      4'b0001: op_res = src_a | src_b;
      4'b0111: op_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
`ifdef ALU_SHIFT_EN
      4'b0011, 4'b0100: begin
        op_res   = src_a;
        op_shift = (shamt != '0);
      end
`endif
      default: op_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
`ifdef ALU_SHIFT_EN
    work_d      = work_q;
    cnt_d       = cnt_q;
    srl_d       = srl_q;
`endif
    case (state_q)
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
`ifdef ALU_SHIFT_EN
      SHIFT: begin
        work_d = srl_q ? (work_q >> 1) : (work_q << 1);
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = work_d;
          zero_d      = (work_d == '0);
          illegal_d   = 1'b0;
        end
      end
`endif
      default: ;
    endcase
    // A new accept overrides the DONE->IDLE drop, giving back-to-back issue
    if (accept) begin
`ifdef ALU_SHIFT_EN
      if (op_shift) begin
        state_d     = SHIFT;
        out_valid_d = 1'b0;
        work_d      = src_a;
        cnt_d       = shamt;
        srl_d       = alu_control[2];
      end else
`endif
      begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        result_d    = op_res;
        zero_d      = (op_res == '0);
        illegal_d   = op_ill;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
`ifdef ALU_SHIFT_EN
      work_q      <= '0;
      cnt_q       <= '0;
      srl_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
`ifdef ALU_SHIFT_EN
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      srl_q       <= srl_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops push expectations, a negedge monitor checks outputs.
`timescale 1ns/1ps
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_control = 4'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard
  logic seen = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk({exp_q[0].name, " result"},  result,        exp_q[0].res);
        chk({exp_q[0].name, " zero"},    32'(zero),     32'(exp_q[0].z));
        chk({exp_q[0].name, " illegal"}, 32'(illegal),  32'(exp_q[0].ill));
        if (!seen) begin
          chk({exp_q[0].name, " latency"}, 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
          seen = 1'b1;
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Call only at posedge+#1; returns at posedge+#1 just after the accepting edge
  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ei,
                       input int lat);
    int w;
    exp_t e;
    w = 0;
    in_valid = 1'b1; alu_control = op; src_a = a; src_b = b;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk({nm, " accept timeout"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.res = er; e.z = (er == 32'd0); e.ill = ei; e.acc = cyc; e.lat = lat; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    #12;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready",  32'(in_ready),  32'd1);
    chk("reset result",    result,         32'd0);
    chk("reset zero",      32'(zero),      32'd1);
    chk("reset illegal",   32'(illegal),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);

    issue("ADD 5+7", 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    step(2);

    issue("SUB eq", 4'b0110, 32'h1234, 32'h1234, 32'd0, 1'b0, 1);
    issue("SLT -1<1", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    issue("SLT 1<-1", 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    issue("ADD wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    issue("SUB neg", 4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
    issue("OR", 4'b0001, 32'h0F00, 32'h00F0, 32'h0FF0, 1'b0, 1);
    issue("ILL 1111", 4'b1111, 32'd3, 32'd4, 32'd0, 1'b1, 1);
    issue("ILL 0101", 4'b0101, 32'd9, 32'd9, 32'd0, 1'b1, 1);
    step(2);

    out_ready = 1'b0;
    issue("AND hold", 4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1);
    repeat (4) begin
      @(negedge clk);
      chk("hold in_ready",  32'(in_ready),  32'd0);
      chk("hold out_valid", 32'(out_valid), 32'd1);
      chk("hold result",    result,         32'hF000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post-release out_valid", 32'(out_valid), 32'd0);
    chk("post-release in_ready",  32'(in_ready),  32'd1);
    step(1);

`ifdef ALU_SHIFT_EN
    issue("SLL 1<<4", 4'b0011, 32'd1, 32'd4, 32'd16, 1'b0, 5);
    issue("SRL >>31", 4'b0100, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 32);
    issue("SLL sh0", 4'b0011, 32'hABCD_0123, 32'd0, 32'hABCD_0123, 1'b0, 1);
    issue("SRL sh32", 4'b0100, 32'h0000_5A5A, 32'd32, 32'h0000_5A5A, 1'b0, 1);
    issue("SRL 0xF0>>4", 4'b0100, 32'h0000_00F0, 32'd4, 32'h0000_000F, 1'b0, 5);
    step(45);
    issue("SLL abort", 4'b0011, 32'd1, 32'd10, 32'd1024, 1'b0, 11);
    step(3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst shift out_valid", 32'(out_valid), 32'd0);
    chk("rst shift in_ready",  32'(in_ready),  32'd1);
    chk("rst shift result",    result,         32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(20);
`else
    issue("SLL disabled", 4'b0011, 32'd1, 32'd4, 32'd0, 1'b1, 1);
    issue("SRL disabled", 4'b0100, 32'h8000_0000, 32'd31, 32'd0, 1'b1, 1);
    step(2);
`endif

    out_ready = 1'b0;
    issue("ADD abort", 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst done out_valid", 32'(out_valid), 32'd0);
    chk("rst done in_ready",  32'(in_ready),  32'd1);
    chk("rst done result",    result,         32'd0);
    chk("rst done zero",      32'(zero),      32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(10);

    issue("ADD after rst", 4'b0010, 32'd100, 32'd23, 32'd123, 1'b0, 1);
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
